led_pwm_fader: RTL and testbench
================================

# led_pwm_fader

Parametrised multi-channel LED driver, the next generation of the board-level LED dimmer. Each channel is driven by a shared free-running PWM counter against a per-channel duty level. The level fades up or down toward a global brightness target at a programmable step rate. Sits between the CPU output register and the physical LED pins and replaces fixed counter-bit duty masking with true per-channel PWM.

## Interface
- CHANNELS, 8, number of LED channels
- PWM_BITS, 7, PWM counter/level width; period = 2^PWM_BITS cycles
- PRESCALE_WIDTH, 16, width of the step-rate divider
- CLOCK  in  1  single clock; all logic on posedge
- RESET  in  1  asynchronous, active-high; clears all state immediately
- ENABLE  in  CHANNELS  per-channel on request, sampled every cycle
- BRIGHTNESS  in  PWM_BITS  global target level; 0 = dark, 2^PWM_BITS-1 = maximum
- STEP_DIV  in  PRESCALE_WIDTH  fade step period minus 1, in CLOCK cycles
- LED  out  CHANNELS  registered PWM outputs
- BUSY  out  1  registered; high while any channel is in RISE or FALL
- PWM_WRAP  out  1  registered one-cycle pulse per PWM period

## Operation
- pwm_cnt: PWM_BITS wide, +1 every cycle, wraps 2^PWM_BITS-1 -> 0.
- PWM_WRAP <= (pwm_cnt == 2^PWM_BITS-1).
- step_cnt counts 0..STEP_DIV. step_tick is high for one cycle when step_cnt == STEP_DIV, and step_cnt returns to 0 on the same edge. STEP_DIV = 0 gives a tick every cycle. A STEP_DIV change takes effect on the next comparison. If step_cnt > STEP_DIV, step_cnt resets to 0 with no tick.
- Per channel: level (PWM_BITS) and state in {OFF, RISE, ON, FALL}.
  - OFF (level 0): ENABLE=1 -> RISE.
  - RISE: ENABLE=0 -> FALL. If level >= BRIGHTNESS -> ON. Otherwise, on step_tick, level+1.
  - ON: ENABLE=0 -> FALL. Otherwise, on step_tick, level moves one step toward BRIGHTNESS (±1, or no change if equal). The state stays ON.
  - FALL: ENABLE=1 -> RISE. Otherwise, on step_tick, level-1. When level == 0 -> OFF.
  - In a cycle with a state transition, level does not change.
- LED[i] <= (level[i] > pwm_cnt).
  - Level L gives L high cycles per 2^PWM_BITS-cycle period.
  - Level 0 is never high.
- Arithmetic is unsigned. Level never wraps: it saturates at 0 and at 2^PWM_BITS-1.
- BUSY <= OR over channels of (state == RISE or state == FALL).

## Timing
- Reset values:
  - pwm_cnt = 0, step_cnt = 0
  - all levels = 0, all states = OFF
  - LED = 0, BUSY = 0, PWM_WRAP = 0
- RESET is asynchronous. Asserting it mid-fade forces LED/BUSY/PWM_WRAP low without waiting for a clock edge. After release, operation resumes from the reset state on the first edge.
- ENABLE edge -> state change on the next CLOCK edge. BUSY follows one cycle after that.
- Level change -> LED reflects it one cycle later (registered compare).
- Full fade 0 -> B with STEP_DIV = D takes B*(D+1) cycles, +1 transition cycle, ±D cycles of step phase.
- ENABLE and step_tick in the same cycle: the transition wins and no step is taken.
- Channels are independent; any number may change state in the same cycle.

## Configuration
- LED_FADE_EN defined: full fade FSM as above.
- LED_FADE_EN undefined:
  - Per channel, level <= ENABLE ? BRIGHTNESS : 0 every cycle, and the state is only OFF/ON.
  - step_cnt and STEP_DIV logic are removed; STEP_DIV is ignored.
  - BUSY is tied to 0.
  - PWM and LED behaviour are unchanged.

## Structure
- Package led_pwm_pkg holds:
  - typedef enum logic [1:0] fade_state_t {OFF, RISE, ON, FALL}
  - default constants for CHANNELS, PWM_BITS, PRESCALE_WIDTH
- Sub-module led_fade_channel holds one channel's state, level and LED compare. It is instantiated CHANNELS times in a generate loop.
- pwm_cnt, step_cnt, PWM_WRAP and the BUSY reduction live in the top module.

## Test plan
(All cases use defaults: CHANNELS=8, PWM_BITS=7, STEP_DIV=3 unless stated.)
- Reset: assert RESET with random inputs -> LED=0, BUSY=0, PWM_WRAP=0 asynchronously; all remain 0 for 5 cycles after release with ENABLE=0.
- Fade-in: BRIGHTNESS=64, ENABLE=8'h01 -> BUSY high next cycle; channel 0 reaches ON after ~257 cycles and BUSY drops; LED[0] high for exactly 64 of every 128 cycles; LED[7:1]=0.
- Reversal: release ENABLE[0] at level 20 during RISE -> FALL next cycle; level reaches 0 after 20 steps (~80 cycles); state OFF, LED[0] stays 0.
- Extremes: BRIGHTNESS=127 in ON -> LED high 127/128 cycles; then BRIGHTNESS=0 -> level decays to 0 while state stays ON, BUSY stays 0, LED never high.
- Rate: STEP_DIV=0 -> level +1 every cycle; PWM_WRAP exactly once per 128 cycles; 8 channels enabled together reach ON in the same cycle.
- LED_FADE_EN undefined: ENABLE=8'hFF, BRIGHTNESS=32 -> all LEDs at 32/128 duty starting 2 cycles after ENABLE; BUSY constantly 0.

Source files
------------

// File: rtl/led_pwm_fader_pkg.sv
// Shared state type and default sizing for the LED PWM fader.
// The fade behaviour is selected at build time with the LED_FADE_EN macro.
package led_pwm_pkg;

  localparam int DEF_CHANNELS       = 8;
  localparam int DEF_PWM_BITS       = 7;
  localparam int DEF_PRESCALE_WIDTH = 16;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    RISE = 2'd1,
    ON   = 2'd2,
    FALL = 2'd3
  } fade_state_t;

endpackage

// File: rtl/led_pwm_fader_if.sv
// Control/status bundle between the CPU output register (master) and the fader (slave).
interface led_pwm_fader_if
  import led_pwm_pkg::*;
#(
  parameter int CHANNELS       = DEF_CHANNELS,
  parameter int PWM_BITS       = DEF_PWM_BITS,
  parameter int PRESCALE_WIDTH = DEF_PRESCALE_WIDTH
);

  logic [CHANNELS-1:0]       enable;
  logic [PWM_BITS-1:0]       brightness;
  logic [PRESCALE_WIDTH-1:0] stepDiv;
  logic [CHANNELS-1:0]       led;
  logic                      busy;
  logic                      pwmWrap;

  modport master (
    output enable, brightness, stepDiv,
    input  led, busy, pwmWrap
  );

  modport slave (
    input  enable, brightness, stepDiv,
    output led, busy, pwmWrap
  );

endinterface

// File: rtl/led_pwm_fader_channel.sv
// One LED channel: fade state, duty level and registered PWM compare.
// With LED_FADE_EN undefined the level simply follows enable/brightness each cycle.
module led_fade_channel
  import led_pwm_pkg::*;
#(
  parameter int PWM_BITS = DEF_PWM_BITS
)
(
  input  logic                clk,
  input  logic                rst,
  input  logic                enable_i,
  input  logic [PWM_BITS-1:0] brightness_i,
  input  logic                stepTick_i,
  input  logic [PWM_BITS-1:0] pwmCnt_i,
  output logic                led_o,
  output logic                active_o
);

  fade_state_t         state_q, state_d;
  logic [PWM_BITS-1:0] level_q, level_d;
  logic                led_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= OFF;
      level_q <= '0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      led_q   <= (level_q > pwmCnt_i);
    end
  end

`ifdef LED_FADE_EN
  // A state transition always takes priority over a level step in the same cycle.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    case (state_q)
      OFF: begin
        if (enable_i) state_d = RISE;
      end
      RISE: begin
        if (!enable_i)                   state_d = FALL;
        else if (level_q >= brightness_i) state_d = ON;
        else if (stepTick_i)             level_d = level_q + 1'b1;
      end
      ON: begin
        if (!enable_i) begin
          state_d = FALL;
        end else if (stepTick_i) begin
          if (level_q < brightness_i)      level_d = level_q + 1'b1;
          else if (level_q > brightness_i) level_d = level_q - 1'b1;
        end
      end
      FALL: begin
        if (enable_i)          state_d = RISE;
        else if (level_q == '0) state_d = OFF;
        else if (stepTick_i)   level_d = level_q - 1'b1;
      end
      default: state_d = OFF;
    endcase
  end

  assign active_o = (state_q == RISE) || (state_q == FALL);
`else
  logic unusedInputs;
  assign unusedInputs = stepTick_i ^ (^state_q);

  always_comb begin
    state_d = enable_i ? ON : OFF;
    level_d = enable_i ? brightness_i : '0;
  end

  assign active_o = 1'b0;
`endif

  assign led_o = led_q;

endmodule

// File: rtl/led_pwm_fader.sv
// Multi-channel LED PWM driver with fade toward a global brightness target.
// Define LED_FADE_EN for the fading FSM; otherwise levels switch instantly and BUSY stays 0.
module led_pwm_fader
  import led_pwm_pkg::*;
#(
  parameter int CHANNELS       = DEF_CHANNELS,
  parameter int PWM_BITS       = DEF_PWM_BITS,
  parameter int PRESCALE_WIDTH = DEF_PRESCALE_WIDTH
)
(
  input  logic         clk,
  input  logic         rst,
  led_pwm_fader_if.slave bus
);

  localparam logic [PWM_BITS-1:0] PWM_MAX = '1;

  logic [PWM_BITS-1:0] pwmCnt_q, pwmCnt_d;
  logic                pwmWrap_q;
  logic                busy_q;
  logic                stepTick;
  logic [CHANNELS-1:0] chanLed;
  logic [CHANNELS-1:0] chanActive;

  always_comb pwmCnt_d = pwmCnt_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwmCnt_q  <= '0;
      pwmWrap_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      pwmCnt_q  <= pwmCnt_d;
      pwmWrap_q <= (pwmCnt_q == PWM_MAX);
      busy_q    <= |chanActive;
    end
  end

`ifdef LED_FADE_EN
  logic [PRESCALE_WIDTH-1:0] stepCnt_q, stepCnt_d;

  // A lowered divider that leaves the counter above it restarts from 0 without a tick.
  always_comb begin
    stepTick  = (stepCnt_q == bus.stepDiv);
    stepCnt_d = (stepCnt_q >= bus.stepDiv) ? '0 : stepCnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stepCnt_q <= '0;
    else     stepCnt_q <= stepCnt_d;
  end
`else
  logic unusedStepDiv;
  assign unusedStepDiv = ^bus.stepDiv;
  assign stepTick      = 1'b0;
`endif

  for (genvar g = 0; g < CHANNELS; g++) begin : gen_chan
    led_fade_channel #(
      .PWM_BITS (PWM_BITS)
    ) u_chan (
      .clk          (clk),
      .rst          (rst),
      .enable_i     (bus.enable[g]),
      .brightness_i (bus.brightness),
      .stepTick_i   (stepTick),
      .pwmCnt_i     (pwmCnt_q),
      .led_o        (chanLed[g]),
      .active_o     (chanActive[g])
    );
  end

  assign bus.led     = chanLed;
  assign bus.busy    = busy_q;
  assign bus.pwmWrap = pwmWrap_q;

endmodule

// File: tb/tb_led_pwm_fader.sv
// Self-checking bench for led_pwm_fader: directed fade scenarios plus random traffic
// against a cycle-level reference model; honours LED_FADE_EN like the design.
module tb_led_pwm_fader;

  localparam int CH     = 8;
  localparam int PB     = 7;
  localparam int PW     = 16;
  localparam int PERIOD = 1 << PB;

  localparam int S_OFF  = 0;
  localparam int S_RISE = 1;
  localparam int S_ON   = 2;
  localparam int S_FALL = 3;

  logic clk;
  logic rst;

  led_pwm_fader_if #(.CHANNELS(CH), .PWM_BITS(PB), .PRESCALE_WIDTH(PW)) bus ();

  led_pwm_fader #(
    .CHANNELS       (CH),
    .PWM_BITS       (PB),
    .PRESCALE_WIDTH (PW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  logic [CH-1:0] enVal;
  logic [PB-1:0] brVal;
  logic [PW-1:0] divVal;

  int            mPwm;
`ifdef LED_FADE_EN
  int            mStep;
`endif
  int            mLevel [CH];
  int            mState [CH];
  logic [CH-1:0] mLed;
  logic          mBusy;
  logic          mWrap;

  int ledHigh [CH];
  int wrapCount;

  task automatic modelReset();
    mPwm = 0;
`ifdef LED_FADE_EN
    mStep = 0;
`endif
    for (int i = 0; i < CH; i++) begin
      mLevel[i] = 0;
      mState[i] = S_OFF;
    end
    mLed  = '0;
    mBusy = 1'b0;
    mWrap = 1'b0;
  endtask

  // Advances the model by one clock edge using the inputs currently on the bus.
  task automatic modelStep();
    int b;
    bit en;
`ifdef LED_FADE_EN
    int tick;
    tick  = (mStep == int'(bus.stepDiv)) ? 1 : 0;
    mStep = (mStep >= int'(bus.stepDiv)) ? 0 : mStep + 1;
`endif
    b     = int'(bus.brightness);
    mWrap = (mPwm == PERIOD - 1);
    mBusy = 1'b0;
    for (int i = 0; i < CH; i++) begin
      mLed[i] = (mLevel[i] > mPwm);
      mBusy   = mBusy | (mState[i] == S_RISE) | (mState[i] == S_FALL);
      en      = bus.enable[i];
`ifdef LED_FADE_EN
      case (mState[i])
        S_OFF:  if (en) mState[i] = S_RISE;
        S_RISE: begin
          if (!en)                 mState[i] = S_FALL;
          else if (mLevel[i] >= b) mState[i] = S_ON;
          else                     mLevel[i] = mLevel[i] + tick;
        end
        S_ON: begin
          if (!en)            mState[i] = S_FALL;
          else if (tick == 1) mLevel[i] = mLevel[i] + ((b > mLevel[i]) ? 1 : 0) - ((b < mLevel[i]) ? 1 : 0);
        end
        S_FALL: begin
          if (en)                  mState[i] = S_RISE;
          else if (mLevel[i] == 0) mState[i] = S_OFF;
          else                     mLevel[i] = mLevel[i] - tick;
        end
        default: ;
      endcase
`else
      mLevel[i] = en ? b : 0;
      mState[i] = en ? S_ON : S_OFF;
`endif
    end
    mPwm = (mPwm + 1) % PERIOD;
  endtask

  task automatic checkOutput(input string tag);
    total++;
    assert (bus.led === mLed) else begin
      bad++;
      $error("[TB] FAIL %s led: got %h expected %h", tag, bus.led, mLed);
    end
    total++;
    assert (bus.busy === mBusy) else begin
      bad++;
      $error("[TB] FAIL %s busy: got %b expected %b", tag, bus.busy, mBusy);
    end
    total++;
    assert (bus.pwmWrap === mWrap) else begin
      bad++;
      $error("[TB] FAIL %s pwm_wrap: got %b expected %b", tag, bus.pwmWrap, mWrap);
    end
  endtask

  // One clock: drive inputs on the falling edge, check just after the rising edge.
  task automatic applyStimulus(input string tag);
    bus.enable     = enVal;
    bus.brightness = brVal;
    bus.stepDiv    = divVal;
    modelStep();
    @(posedge clk);
    #1;
    checkOutput(tag);
    for (int i = 0; i < CH; i++) if (bus.led[i] === 1'b1) ledHigh[i]++;
    if (bus.pwmWrap === 1'b1) wrapCount++;
    @(negedge clk);
  endtask

  task automatic checkDuty(input logic [CH-1:0] mask, input int want, input string tag);
    for (int i = 0; i < CH; i++) ledHigh[i] = 0;
    wrapCount = 0;
    repeat (PERIOD) applyStimulus(tag);
    for (int i = 0; i < CH; i++) begin
      total++;
      assert (ledHigh[i] == (mask[i] ? want : 0)) else begin
        bad++;
        $error("[TB] FAIL %s duty ch%0d: got %0d expected %0d", tag, i, ledHigh[i], mask[i] ? want : 0);
      end
    end
    total++;
    assert (wrapCount == 1) else begin
      bad++;
      $error("[TB] FAIL %s wrap_count: got %0d expected 1", tag, wrapCount);
    end
  endtask

  // Asserted between clock edges so the outputs must clear without an edge.
  task automatic asyncReset(input string tag);
    #2 rst = 1'b1;
    #1;
    modelReset();
    checkOutput(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    rst    = 1'b1;
    enVal  = CH'($urandom);
    brVal  = PB'($urandom);
    divVal = PW'($urandom_range(0, 7));
    bus.enable     = enVal;
    bus.brightness = brVal;
    bus.stepDiv    = divVal;
    modelReset();
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_hold");

    rst    = 1'b0;
    enVal  = '0;
    divVal = PW'(3);
    repeat (5) applyStimulus("post_reset");

    brVal = PB'(64);
    enVal = CH'(1);
    repeat (300) applyStimulus("fadein");
    checkDuty(CH'(1), 64, "fadein_duty");

    asyncReset("fadein_reset");
    enVal = CH'(1);
    for (int k = 0; k < 200 && mLevel[0] < 20; k++) applyStimulus("rev_rise");
    enVal = '0;
    repeat (100) applyStimulus("rev_fall");
    checkDuty(CH'(0), 0, "rev_off");

    enVal = CH'(1);
    brVal = PB'(127);
    repeat (560) applyStimulus("ext_rise");
    checkDuty(CH'(1), 127, "ext_max");
    brVal = '0;
    repeat (560) applyStimulus("ext_decay");
    checkDuty(CH'(1), 0, "ext_zero");

    asyncReset("rate_reset");
    divVal = '0;
    enVal  = '1;
    brVal  = PB'(100);
    repeat (150) applyStimulus("rate");
    checkDuty('1, 100, "rate_duty");

    divVal = PW'(2);
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 19) == 0) enVal = CH'($urandom);
      if ($urandom_range(0, 39) == 0) brVal = PB'($urandom);
      if ($urandom_range(0, 99) == 0) divVal = PW'($urandom_range(0, 4));
      if (c == 600 || c == 1100) asyncReset("rand_reset");
      applyStimulus("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
